// File: rtl/cpu_pkg.sv
// Shared types and constants for the two-port RAM arbiter: FSM state encoding,
// default RAM geometry and the port indices used for grants and the last-grant pointer.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_ACC  = 2'd2,
        ST_DONE = 2'd3
    } arb_state_t;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 32;

    // Port indices double as bit positions in the packed request vector.
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

endpackage : cpu_pkg

// File: rtl/rr_arb2.sv
// Combinational two-way pick: a lone requester wins; a tie goes to the CPU when
// FIXED_PRIO is set, otherwise to the port that did not win last time.
module rr_arb2
    import cpu_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_valid,
    output logic       o_winner
);

    always_comb begin
        o_valid  = |i_req;
        o_winner = PORT_CPU;
        case (i_req)
            2'b01:   o_winner = PORT_CPU;
            2'b10:   o_winner = PORT_DMA;
            2'b11:   o_winner = FIXED_PRIO ? PORT_CPU : ~i_last;
            default: o_winner = PORT_CPU;
        endcase
    end

endmodule : rr_arb2

// File: rtl/mem_arbiter.sv
// Two-port (CPU / DMA) arbiter in front of a single-port synchronous RAM.
// Each granted transaction walks ADDR -> ACC -> DONE; arbitration happens in IDLE and DONE.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              cpu_req,
    input  logic              dma_req,
    input  logic              cpu_we,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              cpu_gnt,
    output logic              dma_gnt,
    output logic              cpu_done,
    output logic              dma_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_rd,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    // Handshake: req is a level; it is sampled only on the edge that issues the
    // grant. gnt stays high through ADDR/ACC/DONE, done pulses for one cycle in
    // DONE together with valid rdata, and a req still high in DONE starts the next
    // transaction back-to-back.

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic              r_cpu_gnt;
    logic              r_dma_gnt;
    logic              r_last;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_dma_rdata;
    logic              w_valid;
    logic              w_winner;
    logic              w_arb_phase;
    logic              w_grant;

    rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_rr_arb2 (
        .i_req    ({dma_req, cpu_req}),
        .i_last   (r_last),
        .o_valid  (w_valid),
        .o_winner (w_winner)
    );

    assign w_arb_phase = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_grant     = w_arb_phase && w_valid;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: w_next_state = w_grant ? ST_ADDR : ST_IDLE;
            ST_ADDR: w_next_state = ST_ACC;
            ST_ACC:  w_next_state = ST_DONE;
            ST_DONE: w_next_state = w_grant ? ST_ADDR : ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Pointer resets to DMA so the CPU wins the first tie after reset.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_cpu_gnt <= 1'b0;
            r_dma_gnt <= 1'b0;
            r_last    <= PORT_DMA;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else if (w_grant) begin
            r_cpu_gnt <= (w_winner == PORT_CPU);
            r_dma_gnt <= (w_winner == PORT_DMA);
            r_last    <= w_winner;
            r_we      <= (w_winner == PORT_DMA) ? dma_we    : cpu_we;
            r_addr    <= (w_winner == PORT_DMA) ? dma_addr  : cpu_addr;
            r_wdata   <= (w_winner == PORT_DMA) ? dma_wdata : cpu_wdata;
        end else if (w_next_state == ST_IDLE) begin
            r_cpu_gnt <= 1'b0;
            r_dma_gnt <= 1'b0;
        end
    end

    // RAM data for a read issued in ADDR is valid during ACC.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_cpu_rdata <= '0;
            r_dma_rdata <= '0;
        end else if ((r_state == ST_ACC) && !r_we) begin
            if (r_cpu_gnt) begin
                r_cpu_rdata <= ram_rdata;
            end
            if (r_dma_gnt) begin
                r_dma_rdata <= ram_rdata;
            end
        end
    end

    assign cpu_gnt   = r_cpu_gnt;
    assign dma_gnt   = r_dma_gnt;
    assign cpu_done  = (r_state == ST_DONE) && r_cpu_gnt;
    assign dma_done  = (r_state == ST_DONE) && r_dma_gnt;
    assign cpu_rdata = r_cpu_rdata;
    assign dma_rdata = r_dma_rdata;
    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;
    assign ram_we    = (r_state == ST_ADDR) && r_we;
    assign ram_rd    = (r_state == ST_ADDR) && !r_we;
    assign busy      = (r_state != ST_IDLE);
    assign dbg_state = r_state;

endmodule : mem_arbiter
